mips_alu_mdu: RTL and testbench

Parametrised successor to the single-cycle datapath ALU. It adds registered outputs, a valid/ready handshake, signed/unsigned compare, overflow detection and an iterative multiply/divide unit with HI/LO registers. It sits in the execute stage of the multi-cycle and pipelined cores. The control FSM stalls on in_ready low and writes back on out_valid.

---
 rtl/mips_alu_mdu.sv | 211 +++++++++++++++++++++
 tb/tb_mips_alu_mdu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_mdu.sv
// Execute-stage ALU with registered outputs, valid/ready handshake and an
// iterative shift-add multiplier / restoring divider writing HI/LO.
module mips_alu_mdu #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam logic [3:0] OpAdd = 4'b0000, OpSub = 4'b0001, OpRsub = 4'b0010, OpOr = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0100, OpAndn = 4'b0101, OpXor = 4'b0110, OpNor = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000, OpSlt = 4'b1001, OpMult = 4'b1010, OpMultu = 4'b1011;
  localparam logic [3:0] OpDiv = 4'b1100, OpMfhi = 4'b1101, OpMflo = 4'b1110;
  localparam int unsigned M = WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [WIDTH-1:0]   r_ph, w_ph_nx, r_pl, w_pl_nx, r_md, w_md_nx;
  logic               r_is_div, w_is_div_nx, r_neg_q, w_neg_q_nx, r_neg_r, w_neg_r_nx;
  logic [WIDTH-1:0]   r_result, w_result_nx, r_hi, w_hi_nx, r_lo, w_lo_nx;
  logic               r_zero, r_ovf, w_ovf_nx, r_dz, w_dz_nx, r_valid, w_valid_nx;

  logic [WIDTH-1:0]   w_b, w_sum, w_dif, w_rdif, w_alu_res, w_a_mag, w_b_mag;
  logic               w_alu_ovf, w_is_md, w_md_signed, w_a_neg, w_b_neg;
  logic [WIDTH:0]     w_mul_sum, w_div_sh, w_div_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_b    = alu_src_b ? imm : src_b;
  assign w_sum  = src_a + w_b;
  assign w_dif  = src_a - w_b;
  assign w_rdif = w_b - src_a;

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (alu_op)
      OpAdd: begin
        w_alu_res = w_sum;
        w_alu_ovf = (src_a[M] == w_b[M]) && (w_sum[M] != src_a[M]);
      end
      OpSub: begin
        w_alu_res = w_dif;
        w_alu_ovf = (src_a[M] != w_b[M]) && (w_dif[M] != src_a[M]);
      end
      OpRsub: begin
        w_alu_res = w_rdif;
        w_alu_ovf = (src_a[M] != w_b[M]) && (w_rdif[M] != w_b[M]);
      end
      OpOr:   w_alu_res = src_a | w_b;
      OpAnd:  w_alu_res = src_a & w_b;
      OpAndn: w_alu_res = ~src_a & w_b;
      OpXor:  w_alu_res = src_a ^ w_b;
      OpNor:  w_alu_res = ~(src_a | w_b);
      OpSltu: w_alu_res = {{M{1'b0}}, (src_a < w_b)};
      OpSlt:  w_alu_res = {{M{1'b0}}, ($signed(src_a) < $signed(w_b))};
      OpMfhi: w_alu_res = r_hi;
      OpMflo: w_alu_res = r_lo;
      default: w_alu_res = '0;
    endcase
  end

  // Mul/div operands always come from src_b; imm[0] selects DIVU.
  assign w_is_md     = (alu_op == OpMult) || (alu_op == OpMultu) || (alu_op == OpDiv);
  assign w_md_signed = (alu_op == OpMult) || ((alu_op == OpDiv) && !imm[0]);
  assign w_a_neg     = w_md_signed && src_a[M];
  assign w_b_neg     = w_md_signed && src_b[M];
  assign w_a_mag     = w_a_neg ? -src_a : src_a;
  assign w_b_mag     = w_b_neg ? -src_b : src_b;

  assign w_mul_sum  = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_md} : '0);
  assign w_div_sh   = {r_ph, r_pl[M]};
  assign w_div_diff = w_div_sh - {1'b0, r_md};
  assign w_prod     = {r_ph, r_pl};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_ph_nx     = r_ph;
    w_pl_nx     = r_pl;
    w_md_nx     = r_md;
    w_is_div_nx = r_is_div;
    w_neg_q_nx  = r_neg_q;
    w_neg_r_nx  = r_neg_r;
    w_result_nx = r_result;
    w_hi_nx     = r_hi;
    w_lo_nx     = r_lo;
    w_ovf_nx    = r_ovf;
    w_dz_nx     = r_dz;
    w_valid_nx  = 1'b0;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (!w_is_md) begin
            w_result_nx = w_alu_res;
            w_ovf_nx    = w_alu_ovf;
            w_dz_nx     = 1'b0;
            w_valid_nx  = 1'b1;
          end else if ((alu_op == OpDiv) && (src_b == '0)) begin
            w_hi_nx     = src_a;
            w_lo_nx     = '1;
            w_result_nx = '1;
            w_ovf_nx    = 1'b0;
            w_dz_nx     = 1'b1;
            w_valid_nx  = 1'b1;
          end else begin
            w_state_nx  = StRun;
            w_cnt_nx    = CNT_W'(WIDTH);
            w_is_div_nx = (alu_op == OpDiv);
            w_neg_q_nx  = w_a_neg ^ w_b_neg;
            w_neg_r_nx  = w_a_neg;
            w_ph_nx     = '0;
            // Mul: r_md = multiplicand, r_pl = multiplier. Div: r_md = divisor, r_pl = dividend.
            w_md_nx     = (alu_op == OpDiv) ? w_b_mag : w_a_mag;
            w_pl_nx     = (alu_op == OpDiv) ? w_a_mag : w_b_mag;
          end
        end
      end
      StRun: begin
        if (r_is_div) begin
          w_ph_nx = w_div_diff[WIDTH] ? w_div_sh[M:0] : w_div_diff[M:0];
          w_pl_nx = {r_pl[M-1:0], ~w_div_diff[WIDTH]};
        end else begin
          w_ph_nx = w_mul_sum[WIDTH:1];
          w_pl_nx = {w_mul_sum[0], r_pl[M:1]};
        end
        w_cnt_nx = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nx = StFin;
      end
      StFin: begin
        if (r_is_div) begin
          w_lo_nx = r_neg_q ? -r_pl : r_pl;
          w_hi_nx = r_neg_r ? -r_ph : r_ph;
        end else begin
          {w_hi_nx, w_lo_nx} = w_prod_fix;
        end
        w_result_nx = w_lo_nx;
        w_ovf_nx    = 1'b0;
        w_dz_nx     = 1'b0;
        w_valid_nx  = 1'b1;
        w_state_nx  = StIdle;
      end
      default: w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_ph     <= '0;
      r_pl     <= '0;
      r_md     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_ph     <= w_ph_nx;
      r_pl     <= w_pl_nx;
      r_md     <= w_md_nx;
      r_is_div <= w_is_div_nx;
      r_neg_q  <= w_neg_q_nx;
      r_neg_r  <= w_neg_r_nx;
      r_result <= w_result_nx;
      r_hi     <= w_hi_nx;
      r_lo     <= w_lo_nx;
      r_zero   <= (w_result_nx == '0);
      r_ovf    <= w_ovf_nx;
      r_dz     <= w_dz_nx;
      r_valid  <= w_valid_nx;
    end
  end

  assign busy      = (r_state != StIdle);
  assign in_ready  = ~busy;
  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign div_zero  = r_dz;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_mips_alu_mdu.sv
// Vector table plus scoreboard bench for mips_alu_mdu (WIDTH = 32).
module tb_mips_alu_mdu;
  localparam int W = 32;
  localparam int MdLat = W + 1;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, alu_src_b = 1'b0;
  logic [3:0] alu_op = '0;
  logic [W-1:0] src_a = '0, src_b = '0, imm = '0;
  logic in_ready, out_valid, zero, overflow, div_zero, busy;
  logic [W-1:0] result, hi, lo;

  mips_alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .src_a(src_a), .src_b(src_b), .imm(imm), .alu_src_b(alu_src_b), .out_valid(out_valid),
    .result(result), .zero(zero), .overflow(overflow), .div_zero(div_zero), .hi(hi), .lo(lo),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic [W-1:0] a, b, imm; logic src;
    logic [W-1:0] res; logic ovf, dz; logic [W-1:0] hi, lo;
  } vec_t;
  typedef struct {
    int id; logic [W-1:0] res; logic z, ovf, dz; logic [W-1:0] hi, lo; int lat, acc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, id, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, b, im,
                              input logic src, input logic [W-1:0] res, input logic ovf, dz,
                              input logic [W-1:0] h, l);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = im; v.src = src;
    v.res = res; v.ovf = ovf; v.dz = dz; v.hi = h; v.lo = l;
    return v;
  endfunction

  task automatic issue(input vec_t v, input int id);
    exp_t e;
    bit md;
    int n = 0;
    @(negedge clk);
    alu_op = v.op; src_a = v.a; src_b = v.b; imm = v.imm; alu_src_b = v.src; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", id, 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    md = (v.op == 4'b1010) || (v.op == 4'b1011) || (v.op == 4'b1100);
    if (md) begin
      m_hi = v.hi;
      m_lo = v.lo;
    end
    e.id = id;
    e.res = md ? v.lo : v.res;
    e.z = (e.res == '0);
    e.ovf = v.ovf;
    e.dz = v.dz;
    e.hi = m_hi;
    e.lo = m_lo;
    e.lat = (md && !(v.op == 4'b1100 && v.b == '0)) ? MdLat : 0;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", -1, 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", e.id, 64'(result), 64'(e.res));
        chk("zero", e.id, 64'(zero), 64'(e.z));
        chk("overflow", e.id, 64'(overflow), 64'(e.ovf));
        chk("div_zero", e.id, 64'(div_zero), 64'(e.dz));
        chk("hi", e.id, 64'(hi), 64'(e.hi));
        chk("lo", e.id, 64'(lo), 64'(e.lo));
        chk("latency", e.id, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic chk_reset(input int id);
    chk("rst_result", id, 64'(result), 64'd0);
    chk("rst_zero", id, 64'(zero), 64'd1);
    chk("rst_out_valid", id, 64'(out_valid), 64'd0);
    chk("rst_overflow", id, 64'(overflow), 64'd0);
    chk("rst_div_zero", id, 64'(div_zero), 64'd0);
    chk("rst_busy", id, 64'(busy), 64'd0);
    chk("rst_in_ready", id, 64'(in_ready), 64'd1);
    chk("rst_hi", id, 64'(hi), 64'd0);
    chk("rst_lo", id, 64'(lo), 64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    // op, a, b, imm, src, res, ovf, dz, hi, lo (hi/lo used for mul/div rows only)
    vecs.push_back(mk(4'b0000, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 1, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 32'h5, 32'h5, 0, 0, 32'h0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0101, 32'hF0F0, 32'hFFFF, 0, 0, 32'h0F0F, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1001, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h1, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1000, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 32'h20, 32'h1234, 32'h10, 1, 32'h30, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0010, 32'h1, 32'h80000000, 0, 0, 32'h7FFFFFFF, 1, 0, 0, 0));
    vecs.push_back(mk(4'b0011, 32'hF0, 32'h0F, 0, 0, 32'hFF, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0110, 32'hFF, 32'h0F, 0, 0, 32'hF0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0111, 32'h0, 32'h0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 32'hF0, 32'h3C, 0, 0, 32'h30, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1111, 32'h5, 32'h6, 0, 0, 32'h0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1010, 32'hFFFFFFFD, 32'h7, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB));
    vecs.push_back(mk(4'b1101, 32'h0, 32'h0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1110, 32'h0, 32'h0, 0, 0, 32'hFFFFFFEB, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1100, 32'hFFFFFFF9, 32'h2, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD));
    vecs.push_back(mk(4'b1100, 32'd100, 32'd7, 32'h1, 1, 0, 0, 0, 32'd2, 32'd14));
    vecs.push_back(mk(4'b1100, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'h0, 32'h80000000));
    vecs.push_back(mk(4'b1100, 32'd9, 32'd0, 32'h1, 0, 0, 0, 1, 32'd9, 32'hFFFFFFFF));
    vecs.push_back(mk(4'b1101, 32'h0, 32'h0, 0, 0, 32'd9, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1011, 32'hFFFFFFFF, 32'h2, 0, 0, 0, 0, 0, 32'h1, 32'hFFFFFFFE));
    vecs.push_back(mk(4'b1110, 32'h0, 32'h0, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 32'h0, 32'h80000000, 0, 0, 32'h80000000, 1, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1 chk_reset(0);
    @(negedge clk) rst = 1'b0;

    // Reset lands three cycles into a MULT; the pending result must never appear.
    issue(mk(4'b1010, 32'hFFFFFFFD, 32'h7, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB), 100);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset(101);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) rst = 1'b0;
    issue(mk(4'b0000, 32'd5, 32'd7, 0, 0, 32'd12, 0, 0, 0, 0), 102);

    foreach (vecs[i]) issue(vecs[i], i);

    // MULTU followed by an ADD held on in_valid while busy.
    issue(mk(4'b1011, 32'h10000, 32'h10000, 0, 0, 0, 0, 0, 32'h1, 32'h0), 200);
    alu_op = 4'b0000; src_a = 32'd1; src_b = 32'd2; alu_src_b = 1'b0; in_valid = 1'b1;
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      chk("busy_in_ready", 200 + k, 64'(in_ready), 64'd0);
    end
    issue(mk(4'b0000, 32'd1, 32'd2, 0, 0, 32'd3, 0, 0, 0, 0), 300);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 999, 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
